// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests to imem and
// buffers in-order responses in a small queue whose head feeds IF/ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        validF
);

  localparam int unsigned PW  = $clog2(QDEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]       fpc_q, fpc_d;
  logic [31:0]       pc_q    [QDEPTH];
  logic [31:0]       pc_d    [QDEPTH];
  logic [31:0]       instr_q [QDEPTH];
  logic [31:0]       instr_d [QDEPTH];
  logic [QDEPTH-1:0] filled_q, filled_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [PW-1:0]     fill_q, fill_d;
  logic [CW-1:0]     occ_q, occ_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic [CW-1:0] n_filled;
  logic [CW-1:0] pending;
  logic          grant;
  logic          pop;

  // Filled bits are cleared on pop, so allocated-but-unfilled = occ - popcount.
  always_comb begin
    n_filled = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      n_filled = n_filled + CW'(filled_q[i]);
    end
    pending = occ_q - n_filled;
  end

  // Handshake and head presentation, all from registered state.
  always_comb begin
    imem_req  = !rst && !redirect &&
                ((CW+1)'(occ_q) + (CW+1)'(drop_q) < (CW+1)'(QDEPTH));
    imem_addr = fpc_q;
    grant     = imem_req && imem_gnt;
    validF    = (occ_q != '0) && filled_q[head_q];
    pop       = validF && !stallF && !redirect;
    instrF    = validF ? instr_q[head_q] : NOP;
    PCF       = validF ? pc_q[head_q] : 32'h0;
    PCPlus4F  = validF ? pc_q[head_q] + 32'd4 : 32'h0;
  end

  always_comb begin
    fpc_d    = fpc_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    filled_d = filled_q;
    head_d   = head_q;
    tail_d   = tail_q;
    fill_d   = fill_q;
    occ_d    = occ_q;
    drop_d   = drop_q;
    if (redirect) begin
      // Everything in flight, including a response arriving now, is wrong-path.
      fpc_d    = {redirect_pc[31:2], 2'b00};
      filled_d = '0;
      head_d   = '0;
      tail_d   = '0;
      fill_d   = '0;
      occ_d    = '0;
      drop_d   = drop_q + pending - CW'(imem_rvalid);
    end else begin
      if (grant) begin
        pc_d[tail_q]     = fpc_q;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PW'(1);
        fpc_d            = fpc_q + 32'd4;
      end
      if (imem_rvalid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          instr_d[fill_q]  = imem_rdata;
          filled_d[fill_q] = 1'b1;
          fill_d           = fill_q + PW'(1);
        end
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
      end
      occ_d = occ_q + CW'(grant) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q    <= RESET_PC;
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      occ_q    <= '0;
      drop_q   <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      fpc_q    <= fpc_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      filled_q <= filled_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      fill_q   <= fill_d;
      occ_q    <= occ_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable in-order imem model
// and a running expected-PC tracker for the presented queue head.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        validF;

  int n_chk = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instrF(instrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .validF(validF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ifn(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model: response sampled by the DUT exactly lat edges after the grant.
  int          lat  = 1;
  int          ecnt = 0;
  logic [31:0] qa[$];
  int          qd[$];

  always @(posedge clk) begin
    if (rst) begin
      qa.delete();
      qd.delete();
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0;
    end else begin
      if (imem_req && imem_gnt) begin
        qa.push_back(imem_addr);
        qd.push_back(ecnt + lat);
      end
      if (qd.size() > 0 && qd[0] <= ecnt + 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= ifn(qa[0]);
        void'(qa.pop_front());
        void'(qd.pop_front());
      end else begin
        imem_rvalid <= 1'b0;
      end
    end
    ecnt <= ecnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  logic        mon_en = 1'b0;
  logic [31:0] exp_addr;
  logic [31:0] exp_pc;

  // Check this cycle's request and head against the tracker, then advance a cycle.
  task automatic tick();
    #1;
    if (mon_en) begin
      if (imem_req) check("imem_addr", imem_addr, exp_addr);
      if (validF) begin
        check("PCF", PCF, exp_pc);
        check("instrF", instrF, ifn(exp_pc));
        check("PCPlus4F", PCPlus4F, exp_pc + 32'd4);
        if (!stallF && !redirect) exp_pc = exp_pc + 32'd4;
      end
      if (imem_req && imem_gnt) exp_addr = exp_addr + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_valid"}, validF, 0);
    check({tag, "_instr"}, instrF, 32'h0000_0013);
    check({tag, "_pc"}, PCF, 0);
    check({tag, "_pc4"}, PCPlus4F, 0);
  endtask

  task automatic reset_dut();
    mon_en      = 1'b0;
    rst         = 1'b1;
    stallF      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("rst");
    rst      = 1'b0;
    exp_addr = 32'h0;
    exp_pc   = 32'h0;
    mon_en   = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 12 && !validF; i++) tick();
    check(tag, validF, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: zero-wait stream from reset
    lat = 1;
    reset_dut();
    #1;
    check("t1_req0", imem_req, 1);
    check("t1_addr0", imem_addr, 32'h0);
    check("t1_v0", validF, 0);
    tick();
    check("t1_v1", validF, 0);
    tick();
    check("t1_v2", validF, 1);
    check("t1_pc2", PCF, 32'h0);
    check("t1_pc4_2", PCPlus4F, 32'h4);
    for (int i = 0; i < 10; i++) begin
      check("t1_stream_v", validF, 1);
      tick();
    end

    // 2: stall for 6 cycles once PCF=8
    reset_dut();
    for (int i = 0; i < 20 && !(validF && PCF == 32'h8); i++) tick();
    check("t2_at8", PCF, 32'h8);
    stallF = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t2_hold_pc", PCF, 32'h8);
      check("t2_hold_instr", instrF, ifn(32'h8));
      check("t2_req", imem_req, (i < 2) ? 1 : 0);
      tick();
    end
    stallF = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t2_rel_v", validF, 1);
      check("t2_rel_pc", PCF, 32'h8 + 32'(4 * k));
      tick();
    end

    // 3: 3-cycle latency, two outstanding, then redirect to 0x103
    lat = 3;
    reset_dut();
    tick();
    tick();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    check("t3_req_redir", imem_req, 0);
    tick();
    redirect = 1'b0;
    imem_gnt = 1'b1;
    exp_addr = 32'h100;
    exp_pc   = 32'h100;
    #1;
    check("t3_fpc", imem_addr, 32'h100);
    for (int i = 0; i < 4; i++) begin
      check("t3_drop_v", validF, 0);
      tick();
    end
    check("t3_v", validF, 1);
    check("t3_pc", PCF, 32'h100);
    check("t3_pc4", PCPlus4F, 32'h104);
    for (int i = 0; i < 4; i++) tick();

    // 4: redirect coincides with the only pending response
    lat = 1;
    reset_dut();
    tick();
    check("t4_rvalid", imem_rvalid, 1);
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    imem_gnt = 1'b1;
    exp_addr = 32'h200;
    exp_pc   = 32'h200;
    check("t4_v_a", validF, 0);
    tick();
    check("t4_v_b", validF, 0);
    tick();
    check("t4_v", validF, 1);
    check("t4_pc", PCF, 32'h200);
    check("t4_instr", instrF, ifn(32'h200));
    for (int i = 0; i < 3; i++) tick();

    // 5: address wrap-around
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    exp_addr = 32'hFFFF_FFF8;
    exp_pc   = 32'hFFFF_FFF8;
    wait_valid("t5_v0");
    check("t5_pc0", PCF, 32'hFFFF_FFF8);
    tick();
    wait_valid("t5_v1");
    check("t5_pc1", PCF, 32'hFFFF_FFFC);
    check("t5_pc4_1", PCPlus4F, 32'h0);
    tick();
    wait_valid("t5_v2");
    check("t5_pc2", PCF, 32'h0);
    check("t5_pc4_2", PCPlus4F, 32'h4);
    tick();

    // 6: asynchronous reset with the queue partially full
    stallF = 1'b1;
    repeat (3) tick();
    check("t6_pre_v", validF, 1);
    #2;
    rst    = 1'b1;
    mon_en = 1'b0;
    #1;
    check_reset_outs("t6_async");
    stallF = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outs("t6_hold");
    rst      = 1'b0;
    exp_addr = 32'h0;
    exp_pc   = 32'h0;
    mon_en   = 1'b1;
    #1;
    check("t6_req", imem_req, 1);
    check("t6_addr", imem_addr, 32'h0);
    tick();
    tick();
    check("t6_v", validF, 1);
    check("t6_pc", PCF, 32'h0);
    for (int i = 0; i < 4; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
